hazard_stall_controller: RTL



---
 rtl/hazard_stall_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Pipeline sequencing controller for the 5-stage MIPS core, placed beside the
// forwarding unit in ID. It resolves the hazards that forwarding cannot:
//   - load-use (EX load feeding the ID instruction),
//   - branch operands compared in ID while still being produced in EX or MEM,
//   - the iterative multiply/divide unit, which this block issues and tracks.
// It also keeps a saturating stalled-cycle counter for performance debug.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Rs_ID, Rt_ID          source registers of the ID instruction
//   UsesRt_ID             ID instruction reads rt
//   Branch_ID             ID instruction is a conditional branch
//   BranchTaken_ID        branch taken (or jump) in ID
//   MulDiv_ID, MfHiLo_ID  ID instruction is mult/div, or mfhi/mflo
//   RegWrite_EX, MemRead_EX, WriteRegAddress_EX    EX stage destination info
//   MemRead_MEM, WriteRegAddress_MEM               MEM stage destination info
//   PCWrite, IFIDWrite    PC and IF/ID enables (low while stalled)
//   IDEXBubble            zero the ID/EX control fields
//   IFIDFlush             clear IF/ID to a NOP (taken branch/jump)
//   MulDivStart           one-cycle start pulse to the mul/div unit
//   MulDivBusy            mul/div operation in flight
//   StallCycles           saturating count of stalled cycles
//
// Stall and flush decisions are combinational so that they act in the same
// cycle the hazard is visible in ID.
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UsesRt_ID,
  input  logic        Branch_ID,
  input  logic        BranchTaken_ID,
  input  logic        MulDiv_ID,
  input  logic        MfHiLo_ID,
  input  logic        RegWrite_EX,
  input  logic        MemRead_EX,
  input  logic [4:0]  WriteRegAddress_EX,
  input  logic        MemRead_MEM,
  input  logic [4:0]  WriteRegAddress_MEM,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic        MulDivStart,
  output logic        MulDivBusy,
  output logic [31:0] StallCycles
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic load_use_s, br_ex_s, br_mem_s, hilo_wait_s, stall_s;

  // True when the ID instruction reads a register written by 'addr'.
  // Register 0 is hard-wired and never a dependency.
  function automatic logic src_match(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt,
    input logic [4:0] addr
  );
    logic rs_m, rt_m;
    rs_m = (rs == addr) && (addr != 5'd0);
    rt_m = uses_rt && (rt == addr) && (addr != 5'd0);
    return rs_m || rt_m;
  endfunction

  // Hazard detection, pipeline control outputs and mul/div next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    IFIDFlush   = 1'b0;
    MulDivStart = 1'b0;

    load_use_s  = MemRead_EX &&
                  src_match(Rs_ID, Rt_ID, UsesRt_ID, WriteRegAddress_EX);
    br_ex_s     = Branch_ID && RegWrite_EX &&
                  src_match(Rs_ID, Rt_ID, UsesRt_ID, WriteRegAddress_EX);
    br_mem_s    = Branch_ID && MemRead_MEM &&
                  src_match(Rs_ID, Rt_ID, UsesRt_ID, WriteRegAddress_MEM);
    hilo_wait_s = (state_q == ST_BUSY) && (MfHiLo_ID || MulDiv_ID);
    stall_s     = load_use_s || br_ex_s || br_mem_s || hilo_wait_s;

    if (stall_s) begin
      // A stalled branch is re-evaluated next cycle, so no flush yet.
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
      IFIDFlush  = 1'b0;
    end else begin
      IFIDFlush = Branch_ID && BranchTaken_ID;
    end

    // One increment per stalled edge regardless of how many causes overlap.
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (MulDiv_ID && !stall_s) begin
          MulDivStart = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Busy flag is a pure function of the state register.
  always_comb begin
    MulDivBusy = (state_q == ST_BUSY);
  end

  assign StallCycles = stall_cnt_q;

  // State, countdown and stall counter registers; reset abandons any op.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
